// File: rtl/screen_pkg.sv
// Shared types and constants for the piano-tiles screen sequencer.
// State encoding is fixed: it is visible on o_state.
package screen_pkg;

    typedef enum logic [1:0] {
        TITLE = 2'd0,
        START = 2'd1,
        PLAY  = 2'd2,
        OVER  = 2'd3
    } screen_state_t;

    localparam int unsigned FRAME_CNT_W = 8;
    localparam logic [FRAME_CNT_W-1:0] FRAME_CNT_MAX = '1;

    localparam logic [7:0] BG_COLOUR_DEFAULT = 8'h00;

endpackage

// File: rtl/screen_pixel_mux.sv
// Two-stage pixel path: aligns sprite-on/active/state with ROM data, then
// registers the colour selected for the current screen.
module screen_pixel_mux
    import screen_pkg::*;
#(
    parameter logic [7:0] BG_COLOUR = BG_COLOUR_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] state,
    input  logic       active,
    input  logic       bsprite_on,
    input  logic       gsprite_on,
    input  logic [7:0] bdata,
    input  logic [7:0] gdata,
    input  logic [7:0] game_pix,
    output logic [7:0] pix,
    output logic       blank
);

    screen_state_t state_s1_q;
    logic          active_s1_q;
    logic          bsprite_s1_q;
    logic          gsprite_s1_q;
    logic [7:0]    pix_d;
    logic [7:0]    pix_q;
    logic          blank_q;

    always_comb begin
        pix_d = 8'h00;
        if (active_s1_q) begin
            case (state_s1_q)
                TITLE:       pix_d = bsprite_s1_q ? bdata : BG_COLOUR;
                START, PLAY: pix_d = game_pix;
                OVER:        pix_d = gsprite_s1_q ? gdata : game_pix;
                default:     pix_d = game_pix;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_s1_q   <= TITLE;
            active_s1_q  <= 1'b0;
            bsprite_s1_q <= 1'b0;
            gsprite_s1_q <= 1'b0;
            pix_q        <= 8'h00;
            blank_q      <= 1'b1;
        end else begin
            state_s1_q   <= screen_state_t'(state);
            active_s1_q  <= active;
            bsprite_s1_q <= bsprite_on;
            gsprite_s1_q <= gsprite_on;
            pix_q        <= pix_d;
            blank_q      <= ~active_s1_q;
        end
    end

    assign pix   = pix_q;
    assign blank = blank_q;

endmodule

// File: rtl/screen_sequencer.sv
// Screen controller: title / start / play / game-over sequencing, game
// run/reset controls, and per-screen pixel source selection.
module screen_sequencer
    import screen_pkg::*;
#(
    parameter int unsigned TITLE_MIN_FRAMES = 30,
    parameter int unsigned OVER_MIN_FRAMES  = 60,
    parameter int unsigned OVER_AUTO_FRAMES = 180,
    parameter logic [7:0]  BG_COLOUR        = BG_COLOUR_DEFAULT
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_frame_start,
    input  logic       i_start_btn,
    input  logic       i_game_over,
    input  logic       i_active,
    input  logic       i_bsprite_on,
    input  logic       i_gsprite_on,
    input  logic [7:0] i_bdata,
    input  logic [7:0] i_gdata,
    input  logic [7:0] i_game_pix,
    output logic [7:0] o_pix,
    output logic       o_blank,
    output logic [1:0] o_state,
    output logic       o_game_run,
    output logic       o_game_reset
);

    localparam logic [FRAME_CNT_W-1:0] TITLE_MIN = FRAME_CNT_W'(TITLE_MIN_FRAMES);
    localparam logic [FRAME_CNT_W-1:0] OVER_MIN  = FRAME_CNT_W'(OVER_MIN_FRAMES);
    localparam logic [FRAME_CNT_W-1:0] OVER_AUTO = FRAME_CNT_W'(OVER_AUTO_FRAMES);

    screen_state_t          state_q;
    screen_state_t          state_d;
    logic [FRAME_CNT_W-1:0] frame_cnt_q;
    logic                   btn_prev_q;
    logic                   start_edge;
    logic                   game_run_q;
    logic                   game_reset_q;

    always_comb begin
        start_edge = i_start_btn & ~btn_prev_q;
        state_d    = state_q;
        case (state_q)
            TITLE: begin
                if (start_edge && frame_cnt_q >= TITLE_MIN) state_d = START;
            end
            START: state_d = PLAY;
            PLAY: begin
                if (i_game_over) state_d = OVER;
            end
            OVER: begin
                // Restart takes priority over the automatic return to title.
                if (start_edge && frame_cnt_q >= OVER_MIN) begin
                    state_d = START;
                end else if (frame_cnt_q >= OVER_AUTO) begin
                    state_d = TITLE;
                end
            end
            default: state_d = TITLE;
        endcase
    end

    // Run/reset are decoded from the next state so they line up with state_q.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= TITLE;
            frame_cnt_q  <= '0;
            btn_prev_q   <= 1'b1;
            game_run_q   <= 1'b0;
            game_reset_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            btn_prev_q   <= i_start_btn;
            game_run_q   <= (state_d == PLAY);
            game_reset_q <= (state_d == START);
            if (state_d != state_q) begin
                frame_cnt_q <= '0;
            end else if (i_frame_start && frame_cnt_q != FRAME_CNT_MAX) begin
                frame_cnt_q <= frame_cnt_q + 8'd1;
            end
        end
    end

    assign o_state      = state_q;
    assign o_game_run   = game_run_q;
    assign o_game_reset = game_reset_q;

    screen_pixel_mux #(
        .BG_COLOUR(BG_COLOUR)
    ) u_pixel_mux (
        .clk       (i_clk),
        .rst       (i_rst),
        .state     (state_q),
        .active    (i_active),
        .bsprite_on(i_bsprite_on),
        .gsprite_on(i_gsprite_on),
        .bdata     (i_bdata),
        .gdata     (i_gdata),
        .game_pix  (i_game_pix),
        .pix       (o_pix),
        .blank     (o_blank)
    );

endmodule

// File: tb/tb_screen_sequencer.sv
// Directed bench for screen_sequencer: screen sequencing, frame gating,
// pixel selection and coincident-event priorities.
module tb_screen_sequencer;

    logic       clk = 1'b0;
    logic       i_rst = 1'b1;
    logic       i_frame_start = 1'b0;
    logic       i_start_btn = 1'b0;
    logic       i_game_over = 1'b0;
    logic       i_active = 1'b0;
    logic       i_bsprite_on = 1'b0;
    logic       i_gsprite_on = 1'b0;
    logic [7:0] i_bdata = 8'h00;
    logic [7:0] i_gdata = 8'h00;
    logic [7:0] i_game_pix = 8'h00;
    logic [7:0] o_pix;
    logic       o_blank;
    logic [1:0] o_state;
    logic       o_game_run;
    logic       o_game_reset;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    screen_sequencer dut (
        .i_clk        (clk),
        .i_rst        (i_rst),
        .i_frame_start(i_frame_start),
        .i_start_btn  (i_start_btn),
        .i_game_over  (i_game_over),
        .i_active     (i_active),
        .i_bsprite_on (i_bsprite_on),
        .i_gsprite_on (i_gsprite_on),
        .i_bdata      (i_bdata),
        .i_gdata      (i_gdata),
        .i_game_pix   (i_game_pix),
        .o_pix        (o_pix),
        .o_blank      (o_blank),
        .o_state      (o_state),
        .o_game_run   (o_game_run),
        .o_game_reset (o_game_reset)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            i_frame_start = 1'b1;
            tick();
            i_frame_start = 1'b0;
            tick();
        end
    endtask

    task automatic apply_reset();
        i_rst = 1'b1;
        tick();
        tick();
        i_rst = 1'b0;
    endtask

    // Flags at cycle N, data at N+1; output is observable after the N+2 edge.
    task automatic pix_drive(input logic act, input logic bs, input logic gs,
                             input logic [7:0] bd, input logic [7:0] gd,
                             input logic [7:0] gp);
        i_active = act;
        i_bsprite_on = bs;
        i_gsprite_on = gs;
        tick();
        i_bdata = bd;
        i_gdata = gd;
        i_game_pix = gp;
        tick();
    endtask

    task automatic test_reset();
        i_start_btn = 1'b0;
        apply_reset();
        checks++;
        if (o_state !== 2'd0) begin
            failures++; $display("FAIL reset_state got=%0d exp=0", o_state);
        end
        checks++;
        if (o_game_run !== 1'b0 || o_game_reset !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl got run=%b rst=%b exp 0 0", o_game_run, o_game_reset);
        end
        checks++;
        if (o_pix !== 8'h00 || o_blank !== 1'b1) begin
            failures++; $display("FAIL reset_pix got pix=%h blank=%b exp 00 1", o_pix, o_blank);
        end
    endtask

    task automatic test_title_pixels();
        pix_drive(1'b1, 1'b1, 1'b0, 8'hA5, 8'hE0, 8'h3C);
        checks++;
        if (o_pix !== 8'hA5 || o_blank !== 1'b0) begin
            failures++; $display("FAIL title_sprite got pix=%h blank=%b exp a5 0", o_pix, o_blank);
        end
        pix_drive(1'b1, 1'b0, 1'b1, 8'hA5, 8'hE0, 8'h3C);
        checks++;
        if (o_pix !== 8'h00 || o_blank !== 1'b0) begin
            failures++; $display("FAIL title_bg got pix=%h blank=%b exp 00 0", o_pix, o_blank);
        end
        pix_drive(1'b0, 1'b1, 1'b0, 8'hA5, 8'hE0, 8'h3C);
        checks++;
        if (o_pix !== 8'h00 || o_blank !== 1'b1) begin
            failures++; $display("FAIL title_inactive got pix=%h blank=%b exp 00 1", o_pix, o_blank);
        end
        i_active = 1'b0; i_bsprite_on = 1'b0; i_gsprite_on = 1'b0;
    endtask

    task automatic test_start_gating();
        i_game_over = 1'b1;
        tick();
        i_game_over = 1'b0;
        checks++;
        if (o_state !== 2'd0) begin
            failures++; $display("FAIL title_ignores_over got=%0d exp=0", o_state);
        end
        frames(10);
        i_start_btn = 1'b1;
        tick();
        checks++;
        if (o_state !== 2'd0 || o_game_reset !== 1'b0) begin
            failures++;
            $display("FAIL early_press got state=%0d rst=%b exp 0 0", o_state, o_game_reset);
        end
        i_start_btn = 1'b0;
        tick();
        frames(20);
        i_start_btn = 1'b1;
        tick();
        checks++;
        if (o_state !== 2'd1 || o_game_reset !== 1'b1 || o_game_run !== 1'b0) begin
            failures++;
            $display("FAIL start_pulse got state=%0d rst=%b run=%b exp 1 1 0",
                     o_state, o_game_reset, o_game_run);
        end
        tick();
        i_start_btn = 1'b0;
        checks++;
        if (o_state !== 2'd2 || o_game_reset !== 1'b0 || o_game_run !== 1'b1) begin
            failures++;
            $display("FAIL enter_play got state=%0d rst=%b run=%b exp 2 0 1",
                     o_state, o_game_reset, o_game_run);
        end
    endtask

    task automatic test_play_pixels();
        pix_drive(1'b1, 1'b1, 1'b1, 8'hA5, 8'hE0, 8'h5A);
        checks++;
        if (o_pix !== 8'h5A || o_blank !== 1'b0) begin
            failures++; $display("FAIL play_pix got pix=%h blank=%b exp 5a 0", o_pix, o_blank);
        end
        i_active = 1'b0; i_bsprite_on = 1'b0; i_gsprite_on = 1'b0;
    endtask

    task automatic test_game_over();
        i_start_btn = 1'b1;
        tick();
        i_start_btn = 1'b0;
        checks++;
        if (o_state !== 2'd2 || o_game_reset !== 1'b0) begin
            failures++;
            $display("FAIL play_ignores_start got state=%0d rst=%b exp 2 0", o_state, o_game_reset);
        end
        // Frame pulse on the transition edge must not count.
        i_game_over = 1'b1;
        i_frame_start = 1'b1;
        tick();
        i_game_over = 1'b0;
        i_frame_start = 1'b0;
        checks++;
        if (o_state !== 2'd3 || o_game_run !== 1'b0) begin
            failures++; $display("FAIL enter_over got state=%0d run=%b exp 3 0", o_state, o_game_run);
        end
        pix_drive(1'b1, 1'b0, 1'b1, 8'hA5, 8'hE0, 8'h3C);
        checks++;
        if (o_pix !== 8'hE0) begin
            failures++; $display("FAIL over_sprite got=%h exp=e0", o_pix);
        end
        pix_drive(1'b1, 1'b1, 1'b0, 8'hA5, 8'hE0, 8'h3C);
        checks++;
        if (o_pix !== 8'h3C) begin
            failures++; $display("FAIL over_game_layer got=%h exp=3c", o_pix);
        end
        i_active = 1'b0; i_bsprite_on = 1'b0; i_gsprite_on = 1'b0;
        frames(59);
        i_start_btn = 1'b1;
        tick();
        i_start_btn = 1'b0;
        checks++;
        if (o_state !== 2'd3 || o_game_reset !== 1'b0) begin
            failures++; $display("FAIL over_press_59 got state=%0d rst=%b exp 3 0", o_state, o_game_reset);
        end
        tick();
        frames(1);
        i_start_btn = 1'b1;
        tick();
        checks++;
        if (o_state !== 2'd1 || o_game_reset !== 1'b1) begin
            failures++; $display("FAIL over_press_60 got state=%0d rst=%b exp 1 1", o_state, o_game_reset);
        end
        tick();
        i_start_btn = 1'b0;
        checks++;
        if (o_state !== 2'd2 || o_game_run !== 1'b1) begin
            failures++; $display("FAIL restart_play got state=%0d run=%b exp 2 1", o_state, o_game_run);
        end
    endtask

    task automatic test_auto_return();
        i_game_over = 1'b1;
        tick();
        i_game_over = 1'b0;
        frames(179);
        checks++;
        if (o_state !== 2'd3) begin
            failures++; $display("FAIL over_hold_179 got=%0d exp=3", o_state);
        end
        i_frame_start = 1'b1;
        tick();
        i_frame_start = 1'b0;
        checks++;
        if (o_state !== 2'd3) begin
            failures++; $display("FAIL over_at_180 got=%0d exp=3", o_state);
        end
        tick();
        checks++;
        if (o_state !== 2'd0 || o_game_reset !== 1'b0 || o_game_run !== 1'b0) begin
            failures++;
            $display("FAIL auto_title got state=%0d rst=%b run=%b exp 0 0 0",
                     o_state, o_game_reset, o_game_run);
        end
    endtask

    task automatic test_restart_wins();
        frames(30);
        i_start_btn = 1'b1;
        tick();
        i_start_btn = 1'b0;
        tick();
        i_game_over = 1'b1;
        tick();
        i_game_over = 1'b0;
        frames(179);
        i_frame_start = 1'b1;
        tick();
        i_frame_start = 1'b0;
        i_start_btn = 1'b1;
        tick();
        i_start_btn = 1'b0;
        checks++;
        if (o_state !== 2'd1 || o_game_reset !== 1'b1) begin
            failures++; $display("FAIL restart_priority got state=%0d rst=%b exp 1 1", o_state, o_game_reset);
        end
        tick();
        checks++;
        if (o_state !== 2'd2) begin
            failures++; $display("FAIL restart_priority_play got=%0d exp=2", o_state);
        end
    endtask

    task automatic test_reset_in_play();
        i_rst = 1'b1;
        tick();
        checks++;
        if (o_state !== 2'd0 || o_game_run !== 1'b0 || o_game_reset !== 1'b0) begin
            failures++;
            $display("FAIL reset_in_play got state=%0d run=%b rst=%b exp 0 0 0",
                     o_state, o_game_run, o_game_reset);
        end
        i_rst = 1'b0;
        tick();
        checks++;
        if (o_state !== 2'd0 || o_game_reset !== 1'b0) begin
            failures++; $display("FAIL reset_no_pulse got state=%0d rst=%b exp 0 0", o_state, o_game_reset);
        end
    endtask

    task automatic test_held_button();
        i_start_btn = 1'b1;
        apply_reset();
        frames(40);
        checks++;
        if (o_state !== 2'd0) begin
            failures++; $display("FAIL held_no_start got=%0d exp=0", o_state);
        end
        i_start_btn = 1'b0;
        tick();
        i_start_btn = 1'b1;
        tick();
        checks++;
        if (o_state !== 2'd1 || o_game_reset !== 1'b1) begin
            failures++; $display("FAIL held_then_press got state=%0d rst=%b exp 1 1", o_state, o_game_reset);
        end
        tick();
        i_start_btn = 1'b0;
        checks++;
        if (o_state !== 2'd2 || o_game_run !== 1'b1) begin
            failures++; $display("FAIL held_play got state=%0d run=%b exp 2 1", o_state, o_game_run);
        end
    endtask

    initial begin
        test_reset();
        test_title_pixels();
        test_start_gating();
        test_play_pixels();
        test_game_over();
        test_auto_return();
        test_restart_wins();
        test_reset_in_play();
        test_held_button();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
